// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Each access runs IDLE -> ISSUE -> RESP; out-of-range addresses skip ISSUE.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DEPTH      = 128,
   parameter int FIXED_PRIO = 0,
   parameter int MAX_WAIT   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   output logic [31:0]       a_rdata,
   output logic              a_ack,
   output logic              a_err,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       b_wdata,
   output logic [31:0]       b_rdata,
   output logic              b_ack,
   output logic              b_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [31:0]       mem_data,
   output logic              mem_hold,
   input  logic [31:0]       mem_q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
   localparam logic [ADDR_W-1:0] LIMIT   = ADDR_W'(DEPTH);

   state_t            r_state;
   state_t            w_next;
   logic              r_sel_b;
   logic              r_we;
   logic              r_err;
   logic              r_last_b;
   logic              r_hold;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_grant;
   logic              w_pick_b;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [31:0]       w_sel_wdata;
   logic              w_sel_oor;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_resp;
   logic [31:0]       w_rdata;

   // Winner selection; ties go to the round-robin pointer or, in fixed mode, to A unless B has starved
   always_comb begin
      w_grant  = 1'b0;
      w_pick_b = 1'b0;
      if ((r_state == IDLE) && (a_req || b_req)) begin
         w_grant = 1'b1;
         if (a_req && b_req) begin
            if (FIXED_PRIO != 0) begin
               w_pick_b = (r_cnt == CNT_MAX);
            end else begin
               w_pick_b = ~r_last_b;
            end
         end else begin
            w_pick_b = b_req;
         end
      end else begin
         w_grant  = 1'b0;
         w_pick_b = 1'b0;
      end
   end

   // Fields of the selected requester and the starvation counter update
   always_comb begin
      w_sel_we    = w_pick_b ? b_we    : a_we;
      w_sel_addr  = w_pick_b ? b_addr  : a_addr;
      w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
      w_sel_oor   = (w_sel_addr >= LIMIT);
      w_cnt_next  = r_cnt;
      if (w_pick_b || !b_req) begin
         w_cnt_next = {CNT_W{1'b0}};
      end else if (r_cnt != CNT_MAX) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_next = w_sel_oor ? RESP : ISSUE;
            end else begin
               w_next = IDLE;
            end
         end
         ISSUE:   w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State, latched transaction and arbitration history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_sel_b  <= 1'b0;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_last_b <= 1'b1;
         r_hold   <= 1'b0;
         r_addr   <= {ADDR_W{1'b0}};
         r_wdata  <= 32'h0000_0000;
         r_cnt    <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_next;
         r_hold  <= (w_next != ISSUE);
         if (w_grant) begin
            r_sel_b  <= w_pick_b;
            r_we     <= w_sel_we;
            r_err    <= w_sel_oor;
            r_last_b <= w_pick_b;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_cnt    <= w_cnt_next;
         end
      end
   end

   // Read data is taken straight from the memory's registered output during RESP
   assign w_resp  = (r_state == RESP);
   assign w_rdata = (w_resp && !r_we && !r_err) ? mem_q : 32'h0000_0000;

   assign mem_addr = r_addr;
   assign mem_data = r_wdata;
   assign mem_we   = (r_state == ISSUE) &  r_we;
   assign mem_re   = (r_state == ISSUE) & ~r_we;
   assign mem_hold = r_hold;

   assign a_ack   = w_resp & ~r_sel_b;
   assign b_ack   = w_resp &  r_sel_b;
   assign a_err   = a_ack & r_err;
   assign b_err   = b_ack & r_err;
   assign a_rdata = a_ack ? w_rdata : 32'h0000_0000;
   assign b_rdata = b_ack ? w_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance, each in front of a small registered-output memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          checks = 0;
   int          failures = 0;

   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [31:0] a_addr = 32'h0, a_wdata = 32'h0, b_addr = 32'h0, b_wdata = 32'h0;
   logic [31:0] a_rdata, b_rdata, mem_addr, mem_data, mem_q;
   logic        a_ack, a_err, b_ack, b_err, mem_we, mem_re, mem_hold;

   logic        f_a_req = 1'b0, f_b_req = 1'b0;
   logic [31:0] f_a_rdata, f_b_rdata, f_mem_addr, f_mem_data, f_mem_q;
   logic        f_a_ack, f_a_err, f_b_ack, f_b_err, f_mem_we, f_mem_re, f_mem_hold;

   logic [31:0] mem0 [128];
   logic [31:0] mem1 [128];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DEPTH(128), .FIXED_PRIO(0), .MAX_WAIT(4)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
      .mem_data(mem_data), .mem_hold(mem_hold), .mem_q(mem_q)
   );

   dmem_arbiter #(.ADDR_W(32), .DEPTH(128), .FIXED_PRIO(1), .MAX_WAIT(4)) u_fp (
      .clk(clk), .reset_n(reset_n),
      .a_req(f_a_req), .a_we(1'b0), .a_addr(32'd3), .a_wdata(32'h0),
      .a_rdata(f_a_rdata), .a_ack(f_a_ack), .a_err(f_a_err),
      .b_req(f_b_req), .b_we(1'b0), .b_addr(32'd4), .b_wdata(32'h0),
      .b_rdata(f_b_rdata), .b_ack(f_b_ack), .b_err(f_b_err),
      .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_re(f_mem_re),
      .mem_data(f_mem_data), .mem_hold(f_mem_hold), .mem_q(f_mem_q)
   );

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem0[i] <= 32'h0;
         mem1[i] <= 32'h0;
      end
      mem0[7] <= 32'h0000_0012;
   end

   // Registered-output memory models
   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'd128) mem0[mem_addr[6:0]] <= mem_data;
      if (mem_re && mem_addr < 32'd128) mem_q <= mem0[mem_addr[6:0]];
      if (f_mem_we && f_mem_addr < 32'd128) mem1[f_mem_addr[6:0]] <= f_mem_data;
      if (f_mem_re && f_mem_addr < 32'd128) f_mem_q <= mem1[f_mem_addr[6:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction on the round-robin instance with latency and strobe accounting
   task automatic xact(input bit port_b, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err, input string tag);
      int  lat;
      int  nwe;
      int  nre;
      bit  got;
      logic hold_k1;
      lat = 0; nwe = 0; nre = 0; got = 1'b0; hold_k1 = 1'bx;
      if (port_b) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      for (int k = 1; k <= 6 && !got; k++) begin
         @(negedge clk);
         nwe += int'(mem_we);
         nre += int'(mem_re);
         if (k == 1) hold_k1 = mem_hold;
         if (port_b ? b_ack : a_ack) begin
            got = 1'b1;
            lat = k;
            chk({tag, "_rdata"}, port_b ? b_rdata : a_rdata, exp_rd);
            chk({tag, "_err"}, {31'd0, port_b ? b_err : a_err}, {31'd0, exp_err});
            chk({tag, "_other_ack"}, {31'd0, port_b ? a_ack : b_ack}, 32'd0);
            chk({tag, "_hold_resp"}, {31'd0, mem_hold}, 32'd1);
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      chk({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
      chk({tag, "_we_cycles"}, 32'(nwe), (we && !exp_err) ? 32'd1 : 32'd0);
      chk({tag, "_re_cycles"}, 32'(nre), (!we && !exp_err) ? 32'd1 : 32'd0);
      chk({tag, "_hold_k1"}, {31'd0, hold_k1}, {31'd0, exp_err});
      @(negedge clk);
      chk({tag, "_ack_pulse"}, {30'd0, a_ack, b_ack}, 32'd0);
   endtask

   int          gcnt;
   int          ts [10];
   logic [9:0]  seq;

   initial begin
      #2;
      chk("rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
      chk("rst_mem_strobes", {29'd0, mem_we, mem_re, mem_hold}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_rdata", a_rdata | b_rdata, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_hold", {31'd0, mem_hold}, 32'd1);

      xact(1'b0, 1'b1, 32'd5,   32'hDEAD_BEEF, 32'h0,         1'b0, "a_wr5");
      xact(1'b0, 1'b0, 32'd5,   32'h0,         32'hDEAD_BEEF, 1'b0, "a_rd5");
      xact(1'b0, 1'b0, 32'd128, 32'h0,         32'h0,         1'b1, "a_rd128");
      xact(1'b0, 1'b1, 32'd127, 32'hFFFF_FFFF, 32'h0,         1'b0, "a_wr127");
      xact(1'b0, 1'b0, 32'd127, 32'h0,         32'hFFFF_FFFF, 1'b0, "a_rd127");
      xact(1'b0, 1'b0, 32'd0,   32'h0,         32'h0,         1'b0, "a_rd0");
      xact(1'b1, 1'b0, 32'd7,   32'h0,         32'h0000_0012, 1'b0, "b_rd7");

      // Both ports request continuously; last grant was B, so A leads
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd7;
      gcnt = 0; seq = 10'd0;
      for (int k = 1; k <= 20 && gcnt < 4; k++) begin
         @(negedge clk);
         chk("rr_no_double", {31'd0, a_ack & b_ack}, 32'd0);
         if (a_ack) begin
            seq[gcnt] = 1'b0; ts[gcnt] = k; gcnt++;
            chk("rr_a_rdata", a_rdata, 32'hDEAD_BEEF);
         end else if (b_ack) begin
            seq[gcnt] = 1'b1; ts[gcnt] = k; gcnt++;
            chk("rr_b_rdata", b_rdata, 32'h0000_0012);
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("rr_grants", 32'(gcnt), 32'd4);
      chk("rr_order", {28'd0, seq[3:0]}, 32'h0000_000A);
      chk("rr_first_lat", 32'(ts[0]), 32'd2);
      chk("rr_spacing", 32'(ts[3] - ts[0]), 32'd9);
      repeat (2) @(negedge clk);
      chk("rr_idle", {30'd0, a_ack, b_ack}, 32'd0);

      // Fixed priority with starvation guard
      f_a_req = 1'b1; f_b_req = 1'b1;
      gcnt = 0; seq = 10'd0;
      for (int k = 1; k <= 40 && gcnt < 10; k++) begin
         @(negedge clk);
         chk("fp_no_double", {31'd0, f_a_ack & f_b_ack}, 32'd0);
         if (f_a_ack) begin
            seq[gcnt] = 1'b0; gcnt++;
         end else if (f_b_ack) begin
            seq[gcnt] = 1'b1; gcnt++;
         end
      end
      f_a_req = 1'b0; f_b_req = 1'b0;
      chk("fp_grants", 32'(gcnt), 32'd10);
      chk("fp_order", {22'd0, seq}, 32'h0000_0210);
      repeat (2) @(negedge clk);

      // Reset while a B write is in ISSUE
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'd9; b_wdata = 32'h0000_0055;
      @(negedge clk);
      chk("rst_issue_we", {31'd0, mem_we}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_mid_strobes", {29'd0, mem_we, mem_re, mem_hold}, 32'd0);
      chk("rst_mid_addr", mem_addr, 32'd0);
      chk("rst_mid_data", mem_data, 32'd0);
      chk("rst_mid_ack", {30'd0, a_ack, b_ack}, 32'd0);
      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      chk("rst_no_b_ack", {31'd0, b_ack}, 32'd0);
      chk("rst_mem_untouched", mem0[9], 32'd0);
      reset_n = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd7;
      gcnt = 0;
      for (int k = 1; k <= 6 && gcnt == 0; k++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            gcnt = 1;
            chk("post_rst_first_a", {30'd0, a_ack, b_ack}, 32'd2);
            chk("post_rst_latency", 32'(k), 32'd2);
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("post_rst_granted", 32'(gcnt), 32'd1);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
